// File: rtl/tcp_gen_pkg.sv
// rtl/tcp_gen_pkg.sv - shared state encoding, TCP state code and beat helpers for the TX traffic generator
package tcp_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EST,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam logic [3:0] TCP_STATE_ESTABLISHED = 4'd3;

    // rem is L % 8; zero means the final beat is full
    function automatic logic [7:0] keep_from_rem(input logic [2:0] rem);
        return (rem == 3'd0) ? 8'hFF : 8'((9'd1 << rem) - 9'd1);
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tcp_tx_pattern_src.sv
// rtl/tcp_tx_pattern_src.sv - running byte-offset pattern former; emits one 64-bit beat and advances on handshake
module tcp_tx_pattern_src
    import tcp_gen_pkg::*;
#(
    parameter int unsigned TCP_DATA_LENGTH = 1456
) (
    input  logic        coreclk_out,
    input  logic        reset,
    input  logic        clear,
    input  logic        advance,
    output logic [63:0] tdata,
    output logic [7:0]  tkeep,
    output logic        tlast
);

    localparam int unsigned NBEATS    = (TCP_DATA_LENGTH + 7) / 8;
    localparam logic [2:0]  REM       = 3'(TCP_DATA_LENGTH % 8);
    localparam logic [7:0]  LAST_KEEP = keep_from_rem(REM);

    logic [7:0]  off_q, off_d;
    logic [31:0] beat_q, beat_d;

    always_comb begin
        tlast = (beat_q == 32'(NBEATS - 1));
        tkeep = tlast ? LAST_KEEP : 8'hFF;
        tdata = '0;
        for (int k = 0; k < 8; k++) begin
            tdata[8*k +: 8] = tkeep[k] ? (off_q + 8'(k)) : 8'h00;
        end
    end

    // offset keeps running across segment boundaries; only clear/reset rewind it
    always_comb begin
        off_d  = off_q;
        beat_d = beat_q;
        if (clear) begin
            off_d  = 8'd0;
            beat_d = 32'd0;
        end else if (advance) begin
            off_d  = off_q + 8'(popcount8(tkeep));
            beat_d = tlast ? 32'd0 : beat_q + 32'd1;
        end
    end

    always_ff @(posedge coreclk_out) begin
        if (reset) begin
            off_q  <= 8'd0;
            beat_q <= 32'd0;
        end else begin
            off_q  <= off_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/tcp_tx_traffic_gen.sv
// rtl/tcp_tx_traffic_gen.sv - TX segment generator and throughput meter; PKT_GAP_EN adds inter-segment idle gaps
module tcp_tx_traffic_gen
    import tcp_gen_pkg::*;
#(
    parameter int unsigned TCP_DATA_LENGTH = 1456,
    parameter logic [3:0]  TCP_ESTABLISHED = TCP_STATE_ESTABLISHED
) (
    input  logic        coreclk_out,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] seg_limit,
    input  logic [15:0] gap_cycles,
    input  logic [3:0]  tcp_state_in,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic        done,
    output logic [31:0] seg_count,
    output logic [63:0] tx_byte_count,
    output logic [63:0] tx_cycle_count
);

    state_e      state_q, state_d;
    logic        stop_pend_q, stop_pend_d;
    logic [31:0] limit_q, limit_d;
    logic [31:0] seg_count_q, seg_count_d;
    logic [63:0] byte_q, byte_d;
    logic [63:0] cyc_q, cyc_d;
    logic        started_q, started_d;

`ifdef PKT_GAP_EN
    logic [15:0] gap_q, gap_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
`else
    logic unused_gap;
    assign unused_gap = ^gap_cycles;
`endif

    logic [63:0] src_tdata;
    logic [7:0]  src_tkeep;
    logic        src_tlast;
    logic        xfer, seg_end, start_ok, stop_now, est, last_seg;

    assign m_axis_tvalid = (state_q == ST_SEND);
    assign xfer          = m_axis_tvalid && m_axis_tready;
    assign seg_end       = xfer && src_tlast;
    assign start_ok      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign stop_now      = stop || stop_pend_q;
    assign est           = (tcp_state_in == TCP_ESTABLISHED);
    assign last_seg      = (limit_q != 32'd0) && ((seg_count_q + 32'd1) == limit_q);
    assign busy          = (state_q == ST_WAIT_EST) || (state_q == ST_SEND) || (state_q == ST_GAP);
    assign done          = (state_q == ST_DONE);

    // idle outputs read as zero rather than exposing the next pending beat
    assign m_axis_tdata  = m_axis_tvalid ? src_tdata : 64'd0;
    assign m_axis_tkeep  = m_axis_tvalid ? src_tkeep : 8'd0;
    assign m_axis_tlast  = m_axis_tvalid && src_tlast;

    assign seg_count      = seg_count_q;
    assign tx_byte_count  = byte_q;
    assign tx_cycle_count = cyc_q;

    tcp_tx_pattern_src #(
        .TCP_DATA_LENGTH(TCP_DATA_LENGTH)
    ) u_src (
        .coreclk_out(coreclk_out),
        .reset      (reset),
        .clear      (start_ok),
        .advance    (xfer),
        .tdata      (src_tdata),
        .tkeep      (src_tkeep),
        .tlast      (src_tlast)
    );

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        limit_d     = limit_q;
        seg_count_d = seg_count_q;
        byte_d      = byte_q;
        cyc_d       = cyc_q;
        started_d   = started_q;
`ifdef PKT_GAP_EN
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_WAIT_EST;
            end
            ST_WAIT_EST: begin
                if (stop_now)  state_d = ST_DONE;
                else if (est)  state_d = ST_SEND;
            end
            ST_SEND: begin
                // the connection state is only acted on at a segment boundary
                if (seg_end) begin
                    if (stop_now || last_seg) state_d = ST_DONE;
                    else if (!est)            state_d = ST_WAIT_EST;
`ifdef PKT_GAP_EN
                    else if (gap_q != 16'd0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q - 16'd1;
                    end
`endif
                end
            end
`ifdef PKT_GAP_EN
            ST_GAP: begin
                if (gap_cnt_q == 16'd0) state_d = stop_now ? ST_DONE : ST_SEND;
                else                    gap_cnt_d = gap_cnt_q - 16'd1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (stop && busy) stop_pend_d = 1'b1;

        if (xfer)    byte_d      = byte_q + 64'(popcount8(src_tkeep));
        if (seg_end) seg_count_d = seg_count_q + 32'd1;
        started_d = started_q || xfer;
        if ((started_q || xfer) && busy && (cyc_q != '1)) cyc_d = cyc_q + 64'd1;

        if (start_ok) begin
            stop_pend_d = 1'b0;
            limit_d     = seg_limit;
            seg_count_d = 32'd0;
            byte_d      = 64'd0;
            cyc_d       = 64'd0;
            started_d   = 1'b0;
`ifdef PKT_GAP_EN
            gap_d       = gap_cycles;
`endif
        end
    end

    always_ff @(posedge coreclk_out) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
            limit_q     <= 32'd0;
            seg_count_q <= 32'd0;
            byte_q      <= 64'd0;
            cyc_q       <= 64'd0;
            started_q   <= 1'b0;
`ifdef PKT_GAP_EN
            gap_q       <= 16'd0;
            gap_cnt_q   <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            limit_q     <= limit_d;
            seg_count_q <= seg_count_d;
            byte_q      <= byte_d;
            cyc_q       <= cyc_d;
            started_q   <= started_d;
`ifdef PKT_GAP_EN
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tcp_tx_traffic_gen.sv
// tb/tb_tcp_tx_traffic_gen.sv - three generator instances (L=1456/40/13) checked against a byte-stream reference model
module tb_tcp_tx_traffic_gen;

    localparam int N = 3;

    function automatic int len_of(input int g);
        return (g == 0) ? 1456 : ((g == 1) ? 40 : 13);
    endfunction

    logic        coreclk_out = 1'b0;
    logic        reset, start, stop, tready;
    logic [31:0] seg_limit;
    logic [15:0] gap_cycles;
    logic [3:0]  tcp_state;

    logic        tvalid [N];
    logic [63:0] tdata  [N];
    logic [7:0]  tkeep  [N];
    logic        tlast  [N];
    logic        busy   [N];
    logic        done   [N];
    logic [31:0] segc   [N];
    logic [63:0] bytec  [N];
    logic [63:0] cycc   [N];

    always #5 coreclk_out = ~coreclk_out;

    for (genvar g = 0; g < N; g++) begin : g_dut
        tcp_tx_traffic_gen #(
            .TCP_DATA_LENGTH(len_of(g)),
            .TCP_ESTABLISHED(4'd3)
        ) u_dut (
            .coreclk_out   (coreclk_out),
            .reset         (reset),
            .start         (start),
            .stop          (stop),
            .seg_limit     (seg_limit),
            .gap_cycles    (gap_cycles),
            .tcp_state_in  (tcp_state),
            .m_axis_tvalid (tvalid[g]),
            .m_axis_tready (tready),
            .m_axis_tdata  (tdata[g]),
            .m_axis_tkeep  (tkeep[g]),
            .m_axis_tlast  (tlast[g]),
            .busy          (busy[g]),
            .done          (done[g]),
            .seg_count     (segc[g]),
            .tx_byte_count (bytec[g]),
            .tx_cycle_count(cycc[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // reference model: payload is a byte stream numbered from run start, cut into L-byte segments
    int     m_segbytes [N];
    int     m_off      [N];
    int     m_segs     [N];
    int     m_xfers    [N];
    longint m_bytes    [N];
    longint first_edge [N];
    longint last_edge  [N];
    bit     in_gap     [N];
    int     idle_run   [N];
    longint edge_cnt = 0;
    int     exp_gap = 0;
    bit     rand_ready = 1'b0;

    task automatic chk(input string tag, input int g, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, g, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int g = 0; g < N; g++) begin
            m_segbytes[g] = 0; m_off[g] = 0; m_segs[g] = 0; m_xfers[g] = 0;
            m_bytes[g] = 0; first_edge[g] = 0; last_edge[g] = 0;
            in_gap[g] = 1'b0; idle_run[g] = 0;
        end
    endtask

    task automatic check_beat(input int g, input logic [63:0] d, input logic [7:0] k, input logic l);
        int rem, n;
        logic [63:0] ed;
        logic [7:0]  ek;
        rem = len_of(g) - m_segbytes[g];
        n   = (rem < 8) ? rem : 8;
        ed  = '0;
        for (int j = 0; j < n; j++) ed[8*j +: 8] = 8'((m_off[g] + j) % 256);
        ek  = 8'((1 << n) - 1);
        chk("tdata", g, d, ed);
        chk("tkeep", g, 64'(k), 64'(ek));
        chk("tlast", g, 64'(l), 64'(rem <= 8));
        if (m_xfers[g] == 0) first_edge[g] = edge_cnt;
        last_edge[g] = edge_cnt;
        m_xfers[g]++;
        m_off[g]   = (m_off[g] + n) % 256;
        m_bytes[g] = m_bytes[g] + longint'(n);
        if (rem <= 8) begin
            m_segs[g]++;
            m_segbytes[g] = 0;
            in_gap[g]     = 1'b1;
            idle_run[g]   = 0;
        end else begin
            m_segbytes[g] = m_segbytes[g] + n;
        end
    endtask

    task automatic tick();
        logic        pv [N];
        logic [63:0] pd [N];
        logic [7:0]  pk [N];
        logic        pl [N];
        logic        pr;
        if (rand_ready) tready = 1'($urandom_range(0, 1));
        @(negedge coreclk_out);
        pr = tready;
        for (int g = 0; g < N; g++) begin
            pv[g] = tvalid[g]; pd[g] = tdata[g]; pk[g] = tkeep[g]; pl[g] = tlast[g];
            if (in_gap[g]) begin
                if (!pv[g]) idle_run[g]++;
                else begin
                    chk("gap_len", g, 64'(idle_run[g]), 64'(exp_gap));
                    in_gap[g] = 1'b0;
                end
            end
            if (pv[g] && pr) check_beat(g, pd[g], pk[g], pl[g]);
        end
        @(posedge coreclk_out);
        edge_cnt++;
        #1;
        for (int g = 0; g < N; g++) begin
            if (pv[g] && !pr) begin
                chk("stall_valid", g, 64'(tvalid[g]), 64'd1);
                chk("stall_data", g, tdata[g], pd[g]);
                chk("stall_keep", g, 64'(tkeep[g]), 64'(pk[g]));
                chk("stall_last", g, 64'(tlast[g]), 64'(pl[g]));
            end
        end
    endtask

    function automatic bit all_done();
        bit r;
        r = 1'b1;
        for (int g = 0; g < N; g++) r = r && (done[g] === 1'b1);
        return r;
    endfunction

    task automatic run_until_done(input int budget, input string tag);
        int i;
        i = 0;
        while (i < budget && !all_done()) begin
            tick();
            i++;
        end
        for (int g = 0; g < N; g++) chk({tag, "_done"}, g, 64'(done[g]), 64'd1);
    endtask

    task automatic pulse_start();
        model_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        for (int g = 0; g < N; g++) begin
            chk({tag, "_tvalid"}, g, 64'(tvalid[g]), 64'd0);
            chk({tag, "_tdata"}, g, tdata[g], 64'd0);
            chk({tag, "_busy"}, g, 64'(busy[g]), 64'd0);
            chk({tag, "_done"}, g, 64'(done[g]), 64'd0);
            chk({tag, "_segs"}, g, 64'(segc[g]), 64'd0);
            chk({tag, "_bytes"}, g, bytec[g], 64'd0);
            chk({tag, "_cycles"}, g, cycc[g], 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b1;
        seg_limit = 32'd0; gap_cycles = 16'd0; tcp_state = 4'd3;
        model_clear();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_idle_zero("reset");

        // two full segments at full rate
        seg_limit = 32'd2;
        pulse_start();
        run_until_done(1000, "full");
        for (int g = 0; g < N; g++) begin
            chk("full_segs", g, 64'(segc[g]), 64'd2);
            chk("full_tlasts", g, 64'(m_segs[g]), 64'd2);
            chk("full_bytes", g, bytec[g], 64'(2 * len_of(g)));
            chk("full_cycles", g, cycc[g], 64'(2 * ((len_of(g) + 7) / 8)));
            chk("full_busy", g, 64'(busy[g]), 64'd0);
        end

        // random back-pressure: model checks every beat, tick checks stall stability
        seg_limit  = 32'd3;
        pulse_start();
        rand_ready = 1'b1;
        run_until_done(5000, "rand");
        rand_ready = 1'b0;
        tready     = 1'b1;
        for (int g = 0; g < N; g++) begin
            chk("rand_segs", g, 64'(segc[g]), 64'd3);
            chk("rand_bytes", g, bytec[g], 64'(3 * len_of(g)));
            chk("rand_cycles", g, cycc[g], 64'(last_edge[g] - first_edge[g] + 1));
        end

        // stop mid-segment in unlimited mode
        seg_limit = 32'd0;
        pulse_start();
        for (int i = 0; i < 50 && m_xfers[0] < 10; i++) tick();
        chk("stop_reach", 0, 64'(m_xfers[0]), 64'd10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_until_done(1000, "stop");
        chk("stop_segs0", 0, 64'(segc[0]), 64'd1);
        for (int g = 0; g < N; g++) begin
            chk("stop_segs", g, 64'(segc[g]), 64'(m_segs[g]));
            chk("stop_bytes", g, bytec[g], 64'(m_bytes[g]));
            chk("stop_whole", g, 64'(m_segbytes[g]), 64'd0);
            chk("stop_tvalid", g, 64'(tvalid[g]), 64'd0);
        end

        // connection drops mid-segment: finish segment, park in WAIT_EST, then stop
        pulse_start();
        for (int i = 0; i < 50 && m_xfers[0] < 20; i++) tick();
        tcp_state = 4'd0;
        repeat (250) tick();
        for (int g = 0; g < N; g++) begin
            chk("drop_tvalid", g, 64'(tvalid[g]), 64'd0);
            chk("drop_busy", g, 64'(busy[g]), 64'd1);
            chk("drop_whole", g, 64'(m_segbytes[g]), 64'd0);
            chk("drop_segs", g, 64'(segc[g]), 64'(m_segs[g]));
            chk("drop_bytes", g, bytec[g], 64'(m_bytes[g]));
        end
        chk("drop_segs0", 0, 64'(segc[0]), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int g = 0; g < N; g++) chk("wait_stop_done", g, 64'(done[g]), 64'd1);
        tcp_state = 4'd3;

`ifdef PKT_GAP_EN
        gap_cycles = 16'd5;
        exp_gap    = 5;
        seg_limit  = 32'd3;
        pulse_start();
        run_until_done(2000, "gap");
        for (int g = 0; g < N; g++) chk("gap_segs", g, 64'(segc[g]), 64'd3);
        gap_cycles = 16'd0;
        exp_gap    = 0;
`endif

        // reset in the middle of a segment
        seg_limit = 32'd0;
        pulse_start();
        repeat (30) tick();
        reset = 1'b1;
        tick();
        check_idle_zero("midreset");
        reset = 1'b0;
        model_clear();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
